// File: rtl/keccak_pkg.sv
// Shared constants and state encoding for the Keccak pad/absorb front end.
// Combinational definitions only; no latency, no flow control.
package keccak_pkg;

    localparam int         RATE_BITS   = 576;
    localparam int         LANE_BITS   = 64;
    localparam int         LANES       = RATE_BITS / LANE_BITS;
    localparam logic [7:0] SHA3_DOMAIN = 8'h06;
    localparam logic [7:0] PAD_END     = 8'h80;

    typedef enum logic [1:0] {
        S_FILL    = 2'd0,
        S_OUT     = 2'd1,
        S_OUT_PAD = 2'd2
    } state_t;

endpackage

// File: rtl/keccak_byte_mask.sv
// Maps a tail byte count to a lane keep-mask and a one-hot first-pad-byte select.
// Purely combinational: zero latency, no backpressure.
module keccak_byte_mask
    import keccak_pkg::*;
(
    input  logic [3:0]           i_nbytes,
    output logic [LANE_BITS-1:0] o_keep,
    output logic [7:0]           o_pad_sel
);

    // A count of 8 (or more) keeps the whole lane and selects no pad byte here.
    always_comb begin
        o_keep    = '0;
        o_pad_sel = '0;
        for (int k = 0; k < 8; k++) begin
            if (4'(k) < i_nbytes) o_keep[8*k +: 8] = 8'hFF;
            if (4'(k) == i_nbytes) o_pad_sel[k] = 1'b1;
        end
    end

endmodule

// File: rtl/keccak_pad_absorb.sv
// Packs 64-bit message words into pad10*1-padded rate blocks for the Keccak permutation.
// Latency: block valid the cycle after its completing word; backpressure: input stalls while a block is held.
module keccak_pad_absorb #(
    parameter int         RATE_BITS = keccak_pkg::RATE_BITS,
    parameter logic [7:0] DOMAIN    = keccak_pkg::SHA3_DOMAIN
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [63:0]          in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_last,
    input  logic [3:0]           in_nbytes,
    output logic [RATE_BITS-1:0] out_block,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_first,
    output logic                 out_last
);
    import keccak_pkg::*;

    localparam int LANES_P = RATE_BITS / LANE_BITS;
    localparam int LC_W    = $clog2(LANES_P);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [LC_W-1:0]      r_lc;
    logic [LC_W-1:0]      w_lc_inc;
    logic [LANE_BITS-1:0] r_lane [LANES_P];
    logic                 r_pad_pending;
    logic                 r_first;
    logic                 r_last;

    logic                 w_in_acc;
    logic                 w_out_acc;
    logic                 w_lc_end;
    logic                 w_full;
    logic                 w_fill_done;
    logic [LANE_BITS-1:0] w_keep;
    logic [7:0]           w_pad_sel;
    logic [LANE_BITS-1:0] w_dom_lane;
    logic [LANE_BITS-1:0] w_dom_lane0;
    logic [LANE_BITS-1:0] w_end_lane;
    logic [RATE_BITS-1:0] w_buf_blk;
    logic [RATE_BITS-1:0] w_pad_blk;

    keccak_byte_mask u_mask (
        .i_nbytes  (in_nbytes),
        .o_keep    (w_keep),
        .o_pad_sel (w_pad_sel)
    );

    // Handshakes decode from registered state so out_ready never reaches in_ready.
    assign w_in_acc    = in_valid && (r_state == S_FILL);
    assign w_out_acc   = out_ready && (r_state != S_FILL);
    assign w_lc_end    = (r_lc == LC_W'(LANES_P - 1));
    assign w_lc_inc    = r_lc + LC_W'(1);
    assign w_full      = (in_nbytes >= 4'd8);
    assign w_fill_done = w_in_acc && (in_last || w_lc_end);
    assign w_dom_lane0 = {{(LANE_BITS-8){1'b0}}, DOMAIN};
    assign w_end_lane  = {PAD_END, {(LANE_BITS-8){1'b0}}};

    always_comb begin
        w_dom_lane = '0;
        for (int k = 0; k < 8; k++) begin
            if (w_pad_sel[k]) w_dom_lane[8*k +: 8] = DOMAIN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_FILL;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_FILL: begin
                in_ready = 1'b1;
                if (w_fill_done) w_state_nxt = S_OUT;
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = r_pad_pending ? S_OUT_PAD : S_FILL;
            end
            S_OUT_PAD: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = S_FILL;
            end
            default: w_state_nxt = S_FILL;
        endcase
    end

    // Later writes in this block deliberately override earlier ones to the same lane.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_lc          <= '0;
            r_pad_pending <= 1'b0;
            r_first       <= 1'b1;
            r_last        <= 1'b0;
            for (int i = 0; i < LANES_P; i++) r_lane[i] <= '0;
        end else if (w_in_acc) begin
            if (!in_last) begin
                r_lane[r_lc] <= in_data;
                r_last       <= 1'b0;
                if (!w_lc_end) r_lc <= w_lc_inc;
            end else begin
                if (!w_lc_end) r_lane[LANES_P-1] <= w_end_lane;
                if (w_full && !w_lc_end)
                    r_lane[w_lc_inc] <= w_dom_lane0 |
                        ((w_lc_inc == LC_W'(LANES_P - 1)) ? w_end_lane : '0);
                r_lane[r_lc] <= (in_data & w_keep) | w_dom_lane |
                                ((w_lc_end && !w_full) ? w_end_lane : '0);
                r_last        <= !(w_lc_end && w_full);
                r_pad_pending <= w_lc_end && w_full;
            end
        end else if (w_out_acc) begin
            r_lc   <= '0;
            r_last <= 1'b0;
            for (int i = 0; i < LANES_P; i++) r_lane[i] <= '0;
            if (r_state == S_OUT) begin
                r_first <= r_last;
            end else begin
                r_first       <= 1'b1;
                r_pad_pending <= 1'b0;
            end
        end
    end

    always_comb begin
        w_buf_blk = '0;
        for (int i = 0; i < LANES_P; i++) w_buf_blk[LANE_BITS*i +: LANE_BITS] = r_lane[i];
    end

    always_comb begin
        w_pad_blk                  = '0;
        w_pad_blk[7:0]             = DOMAIN;
        w_pad_blk[RATE_BITS-1 -: 8] = PAD_END;
    end

    assign out_block = (r_state == S_OUT_PAD) ? w_pad_blk : w_buf_blk;
    assign out_first = r_first;
    assign out_last  = (r_state == S_OUT_PAD) || ((r_state == S_OUT) && r_last);

endmodule

// File: tb/tb_keccak_pad_absorb.sv
// Directed bench for keccak_pad_absorb: table of messages plus hand sequences.
module tb_keccak_pad_absorb;

    localparam int RB    = 576;
    localparam int NBYTE = RB / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [63:0]   in_data;
    logic          in_valid;
    logic          in_ready;
    logic          in_last;
    logic [3:0]    in_nbytes;
    logic [RB-1:0] out_block;
    logic          out_valid;
    logic          out_ready;
    logic          out_first;
    logic          out_last;

    keccak_pad_absorb dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .in_nbytes (in_nbytes),
        .out_block (out_block),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_first (out_first),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [RB-1:0] blk;
        logic          first;
        logic          last;
    } blk_t;

    typedef struct {
        int         len;
        int         seed;
        int         pct;
        int         exp_nblk;
        logic [7:0] exp_b71;
    } vec_t;

    blk_t       got_q[$];
    blk_t       exp_q[$];
    logic [7:0] m_bytes[$];
    int         total = 0;
    int         bad = 0;
    int         ready_pct = 100;
    logic       held;
    blk_t       held_b;

    always @(posedge clk)
        if (in_valid && in_last) assert (in_nbytes <= 4'd8) else $error("in_nbytes out of range");

    task automatic chk(input string name, input logic [RB-1:0] act, input logic [RB-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Sink: random out_ready, records accepted blocks, checks stability while stalled.
    initial begin
        out_ready = 1'b0;
        held      = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                held = 1'b0;
            end else if (held) begin
                chk("stall_valid", RB'(out_valid), RB'(1));
                chk("stall_block", out_block, held_b.blk);
                chk("stall_flags", RB'({out_first, out_last}), RB'({held_b.first, held_b.last}));
                held = 1'b0;
            end
            out_ready = (int'($urandom_range(99)) < ready_pct);
            if (rst && out_valid) begin
                if (out_ready) begin
                    got_q.push_back('{out_block, out_first, out_last});
                end else begin
                    held   = 1'b1;
                    held_b = '{out_block, out_first, out_last};
                end
            end
        end
    end

    task automatic send_word(input logic [63:0] d, input logic l, input logic [3:0] nb);
        int budget;
        budget    = 2000;
        in_data   = d;
        in_last   = l;
        in_nbytes = nb;
        in_valid  = 1'b1;
        while (!in_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        total++;
        if (budget == 0) begin
            bad++;
            $display("FAIL in_ready_timeout: in_ready=%0b want 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic gen_bytes(input int len, input int seed);
        m_bytes.delete();
        for (int j = 0; j < len; j++) m_bytes.push_back(8'(seed + 13 * j + 1));
    endtask

    task automatic send_msg();
        int         len;
        int         nw;
        int         nb;
        logic       l;
        logic [63:0] d;
        len = m_bytes.size();
        nw  = (len == 0) ? 1 : (len + 7) / 8;
        for (int w = 0; w < nw; w++) begin
            d  = {8{8'hEE}};
            l  = (w == nw - 1);
            nb = l ? len - 8 * w : 8;
            for (int k = 0; k < 8; k++)
                if (8 * w + k < len) d[8*k +: 8] = m_bytes[8*w+k];
            send_word(d, l, 4'(nb));
        end
    endtask

    // Byte-level SHA-3 padding reference.
    task automatic model_push();
        int         len;
        int         nblk;
        logic [7:0] pb[$];
        blk_t       b;
        len  = m_bytes.size();
        nblk = len / NBYTE + 1;
        for (int i = 0; i < nblk * NBYTE; i++) pb.push_back(i < len ? m_bytes[i] : 8'h00);
        pb[len]              = pb[len] | 8'h06;
        pb[nblk * NBYTE - 1] = pb[nblk * NBYTE - 1] | 8'h80;
        for (int bi = 0; bi < nblk; bi++) begin
            b.blk = '0;
            for (int j = 0; j < NBYTE; j++) b.blk[8*j +: 8] = pb[bi * NBYTE + j];
            b.first = (bi == 0);
            b.last  = (bi == nblk - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic wait_blocks(input int n);
        int budget;
        budget = 3000;
        while (got_q.size() < n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        total++;
        if (got_q.size() < n) begin
            bad++;
            $display("FAIL block_timeout: got %0d blocks want %0d", got_q.size(), n);
        end
    endtask

    task automatic compare_all(input string tag);
        wait_blocks(exp_q.size());
        repeat (5) @(negedge clk);
        chk($sformatf("%s count", tag), RB'(got_q.size()), RB'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk($sformatf("%s blk%0d data", tag, i), got_q[i].blk, exp_q[i].blk);
            chk($sformatf("%s blk%0d first", tag, i), RB'(got_q[i].first), RB'(exp_q[i].first));
            chk($sformatf("%s blk%0d last", tag, i), RB'(got_q[i].last), RB'(exp_q[i].last));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk($sformatf("%s in_ready", tag), RB'(in_ready), RB'(1));
        chk($sformatf("%s out_valid", tag), RB'(out_valid), RB'(0));
        chk($sformatf("%s out_block", tag), out_block, '0);
        chk($sformatf("%s out_first", tag), RB'(out_first), RB'(1));
        chk($sformatf("%s out_last", tag), RB'(out_last), RB'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          vt[10];
        logic [RB-1:0] e;
        logic [3:0]    fl;
        logic [3:0]    ll;

        vt[0] = '{0,   0, 100, 1, 8'h80};
        vt[1] = '{7,   3, 100, 1, 8'h80};
        vt[2] = '{8,   9,  60, 1, 8'h80};
        vt[3] = '{64,  1, 100, 1, 8'h80};
        vt[4] = '{70,  4,  40, 1, 8'h80};
        vt[5] = '{71,  7, 100, 1, 8'h86};
        vt[6] = '{72,  2,  70, 2, 8'h80};
        vt[7] = '{100, 6,  30, 2, 8'h80};
        vt[8] = '{143, 8, 100, 2, 8'h86};
        vt[9] = '{144, 5,  50, 3, 8'h80};

        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        in_nbytes = '0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            ready_pct = vt[i].pct;
            gen_bytes(vt[i].len, vt[i].seed);
            model_push();
            send_msg();
            wait_blocks(vt[i].exp_nblk);
            repeat (3) @(negedge clk);
            chk($sformatf("vec%0d hand_nblk", i), RB'(got_q.size()), RB'(vt[i].exp_nblk));
            if (got_q.size() > 0)
                chk($sformatf("vec%0d hand_b71", i), RB'(got_q[got_q.size()-1].blk[RB-1 -: 8]),
                    RB'(vt[i].exp_b71));
            compare_all($sformatf("vec%0d", i));
        end

        // "abc" with junk above the valid bytes
        ready_pct = 100;
        send_word(64'hDEADBEEF_AA636261, 1'b1, 4'd3);
        wait_blocks(1);
        e             = '0;
        e[23:0]       = 24'h636261;
        e[31:24]      = 8'h06;
        e[RB-1 -: 8]  = 8'h80;
        if (got_q.size() > 0) begin
            chk("abc block", got_q[0].blk, e);
            chk("abc first", RB'(got_q[0].first), RB'(1));
            chk("abc last", RB'(got_q[0].last), RB'(1));
        end
        repeat (3) @(negedge clk);
        chk("abc count", RB'(got_q.size()), RB'(1));
        got_q.delete();

        // Back-to-back 144-byte message then "abc" under random stalls
        ready_pct = 50;
        gen_bytes(144, 11);
        model_push();
        send_msg();
        m_bytes.delete();
        m_bytes.push_back(8'h61);
        m_bytes.push_back(8'h62);
        m_bytes.push_back(8'h63);
        model_push();
        send_msg();
        wait_blocks(4);
        fl = '0;
        ll = '0;
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            fl[i] = got_q[i].first;
            ll[i] = got_q[i].last;
        end
        chk("b2b first flags", RB'(fl), RB'(4'b1001));
        chk("b2b last flags", RB'(ll), RB'(4'b1100));
        compare_all("b2b");

        // Reset while a full block waits at the output
        ready_pct = 0;
        gen_bytes(72, 21);
        for (int w = 0; w < 9; w++)
            send_word({m_bytes[8*w+7], m_bytes[8*w+6], m_bytes[8*w+5], m_bytes[8*w+4],
                       m_bytes[8*w+3], m_bytes[8*w+2], m_bytes[8*w+1], m_bytes[8*w]}, 1'b0, 4'd8);
        repeat (3) @(negedge clk);
        chk("held out_valid", RB'(out_valid), RB'(1));
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("rst_out");
        rst = 1'b1;
        ready_pct = 100;
        repeat (10) @(negedge clk);
        chk("rst_out no block", RB'(got_q.size()), RB'(0));

        // Reset after 4 words of a message, then the empty message
        for (int w = 0; w < 4; w++) send_word(64'h0123456789ABCDEF + 64'(w), 1'b0, 4'd8);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("rst_mid");
        rst = 1'b1;
        @(negedge clk);
        m_bytes.delete();
        model_push();
        send_msg();
        compare_all("rst_empty");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
